// File: rtl/alu_mdu.sv
// alu_mdu: handshaked RISC-V integer execute unit.
// Covers the RV32I/RV64I register-register ALU ops and the M-extension
// multiply/divide group. ALU ops, multiplies and divide fast paths complete
// one cycle after acceptance. Normal divides run a restoring divider that
// retires one quotient bit per cycle for XLEN cycles.
module alu_mdu #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] lhs,
  input  logic [XLEN-1:0] rhs,
  input  logic [2:0]      func,
  input  logic            alt,
  input  logic            muldiv,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic {IDLE, DIV} state_t;

  // XLEN is a power of two, so the last divide step index is all ones.
  localparam logic [SHW-1:0] LAST_STEP = '1;

  state_t            state, state_nxt;
  logic [SHW-1:0]    count;

  // Divider working registers: quotient/dividend shifter, partial remainder,
  // divisor magnitude and the post-correction flags.
  logic [XLEN-1:0]   quo, rem, dsr;
  logic              is_rem, neg_q, neg_r;

  logic              accept, div_start, div_done, complete;
  logic              div_signed, div_zero, div_ovf;
  logic              mul_a_sgn, mul_b_sgn;
  logic [2*XLEN-1:0] mul_a, mul_b, prod;
  logic [XLEN-1:0]   lhs_mag, rhs_mag;
  logic [XLEN:0]     r_sh, trial;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic [XLEN-1:0]   alu_res, div_res, complete_val;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign busy     = (state == DIV);
  assign accept   = in_valid && in_ready;

  // Divide classification: divide by zero and signed overflow never iterate.
  assign div_signed = !func[0];
  assign div_zero   = (rhs == '0);
  assign div_ovf    = div_signed && (lhs == {1'b1, {(XLEN-1){1'b0}}}) && (rhs == '1);
  assign div_start  = muldiv && func[2] && !div_zero && !div_ovf;

  // Full 2*XLEN product of sign/zero-extended operands; low half of the
  // extended product is exact for every signedness combination.
  assign mul_a_sgn = lhs[XLEN-1] && ((func == 3'd1) || (func == 3'd2));
  assign mul_b_sgn = rhs[XLEN-1] && (func == 3'd1);
  assign mul_a     = {{XLEN{mul_a_sgn}}, lhs};
  assign mul_b     = {{XLEN{mul_b_sgn}}, rhs};
  assign prod      = mul_a * mul_b;

  // Operand magnitudes for the divider; unsigned ops pass through.
  assign lhs_mag = (div_signed && lhs[XLEN-1]) ? -lhs : lhs;
  assign rhs_mag = (div_signed && rhs[XLEN-1]) ? -rhs : rhs;

  // One restoring step: shift in the next dividend bit, trial subtract,
  // keep the difference only if it did not go negative.
  assign r_sh    = {rem, quo[XLEN-1]};
  assign trial   = r_sh - {1'b0, dsr};
  assign quo_nxt = {quo[XLEN-2:0], !trial[XLEN]};
  assign rem_nxt = trial[XLEN] ? r_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign div_res = is_rem ? (neg_r ? -rem_nxt : rem_nxt)
                          : (neg_q ? -quo_nxt : quo_nxt);

  assign div_done     = (state == DIV) && (count == LAST_STEP);
  assign complete     = (accept && !div_start) || div_done;
  assign complete_val = div_done ? div_res : alu_res;

  // Single-cycle result: base ALU ops, multiplies and divide fast paths.
  always_comb begin
    // NOTE: default assigned first so every path drives alu_res (no latch).
    alu_res = '0;
    if (!muldiv) begin
      unique case (func)
        3'd0: alu_res = alt ? (lhs - rhs) : (lhs + rhs);
        3'd1: alu_res = lhs << rhs[SHW-1:0];
        3'd2: alu_res = {{(XLEN-1){1'b0}}, $signed(lhs) < $signed(rhs)};
        3'd3: alu_res = {{(XLEN-1){1'b0}}, lhs < rhs};
        3'd4: alu_res = lhs ^ rhs;
        3'd5: begin
          // Kept as if/else: inside ?: the unsigned arm would force a logical shift.
          if (alt) alu_res = $signed(lhs) >>> rhs[SHW-1:0];
          else     alu_res = lhs >> rhs[SHW-1:0];
        end
        3'd6: alu_res = lhs | rhs;
        3'd7: alu_res = lhs & rhs;
      endcase
    end else begin
      unique case (func)
        3'd0:                   alu_res = prod[XLEN-1:0];
        3'd1, 3'd2, 3'd3:       alu_res = prod[2*XLEN-1:XLEN];
        3'd4, 3'd5, 3'd6, 3'd7: begin
          if (func[1]) alu_res = div_zero ? lhs : '0;
          else         alu_res = div_zero ? '1  : lhs;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state always uses non-blocking assignments.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: enter DIV on an iterating divide, leave after the last step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && div_start) state_nxt = DIV;
      DIV:  if (count == LAST_STEP)  state_nxt = IDLE;
    endcase
  end

  // Step counter; restarts at zero on every divide.
  always_ff @(posedge clk) begin
    if (rst)                     count <= '0;
    else if (accept && div_start) count <= '0;
    else if (state == DIV)       count <= count + 1'b1;
  end

  // Divider datapath: load magnitudes and signs on start, iterate in DIV.
  always_ff @(posedge clk) begin
    // NOTE: no reset here; these are always loaded at divide start before use.
    if (accept && div_start) begin
      quo    <= lhs_mag;
      rem    <= '0;
      dsr    <= rhs_mag;
      is_rem <= func[1];
      neg_q  <= div_signed && (lhs[XLEN-1] ^ rhs[XLEN-1]);
      neg_r  <= div_signed && lhs[XLEN-1];
    end else if (state == DIV) begin
      quo <= quo_nxt;
      rem <= rem_nxt;
    end
  end

  // Output register: a completion always wins; otherwise a consumed result drops valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      result    <= complete_val;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: self-checking bench for alu_mdu at XLEN=32 (unit 0) and
// XLEN=64 (unit 1). A behavioural model predicts results from plain
// wide arithmetic, and a cycle-level handshake model predicts when they appear.
module tb_alu_mdu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid [2];
  logic        out_ready[2];
  logic        alt      [2];
  logic        muldiv   [2];
  logic [63:0] lhs      [2];
  logic [63:0] rhs      [2];
  logic [2:0]  func     [2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        busy     [2];
  logic [31:0] res32;
  logic [63:0] res64;
  logic [63:0] result   [2];

  assign result[0] = {32'h0, res32};
  assign result[1] = res64;

  alu_mdu #(.XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .lhs(lhs[0][31:0]), .rhs(rhs[0][31:0]),
    .func(func[0]), .alt(alt[0]), .muldiv(muldiv[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .result(res32), .busy(busy[0])
  );

  alu_mdu #(.XLEN(64)) u_dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .lhs(lhs[1]), .rhs(rhs[1]),
    .func(func[1]), .alt(alt[1]), .muldiv(muldiv[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .result(res64), .busy(busy[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] xmask(input int xl);
    return (xl == 32) ? 64'h0000_0000_FFFF_FFFF : {64{1'b1}};
  endfunction

  function automatic logic [63:0] model(input int xl, input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] f, input logic al, input logic md);
    logic [63:0]         m;
    logic signed [127:0] sa, sb;
    logic [127:0]        ua, ub, t;
    int                  sh;
    m  = xmask(xl);
    ua = {64'h0, a & m};
    ub = {64'h0, b & m};
    if (xl == 32) begin
      sa = {{96{a[31]}}, a[31:0]};
      sb = {{96{b[31]}}, b[31:0]};
      sh = int'(b[4:0]);
    end else begin
      sa = {{64{a[63]}}, a};
      sb = {{64{b[63]}}, b};
      sh = int'(b[5:0]);
    end
    t = '0;
    if (!md) begin
      case (f)
        3'd0: if (al) t = ua - ub; else t = ua + ub;
        3'd1: t = ua << sh;
        3'd2: t = {127'h0, sa < sb};
        3'd3: t = {127'h0, ua < ub};
        3'd4: t = ua ^ ub;
        3'd5: if (al) t = sa >>> sh; else t = ua >> sh;
        3'd6: t = ua | ub;
        default: t = ua & ub;
      endcase
    end else begin
      case (f)
        3'd0: t = ua * ub;
        3'd1: t = (sa * sb) >> xl;
        3'd2: t = (sa * ub) >> xl;
        3'd3: t = (ua * ub) >> xl;
        3'd4: if (ub == 0) t = '1; else t = sa / sb;
        3'd5: if (ub == 0) t = '1; else t = ua / ub;
        3'd6: if (ub == 0) t = ua; else t = sa % sb;
        default: if (ub == 0) t = ua; else t = ua % ub;
      endcase
    end
    return t[63:0] & m;
  endfunction

  // True when the op takes the multi-cycle divide path.
  function automatic bit long_div(input int xl, input logic [63:0] a, input logic [63:0] b,
                                  input logic [2:0] f, input logic md);
    logic [63:0] m, minv;
    m    = xmask(xl);
    minv = (xl == 32) ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
    return md && f[2] && ((b & m) != 0) && !(!f[0] && ((a & m) == minv) && ((b & m) == m));
  endfunction

  // ---------------- cycle-level handshake model + compare ----------------
  bit          armed = 0;
  bit          holding   [2];
  logic [63:0] hold_val  [2];
  int          div_left  [2];
  logic [63:0] div_val   [2];
  bit          zero_known[2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    int          xl;
    bit          exp_ir, acc, done;
    logic [63:0] dval, mv;
    string       tag;
    if (armed) begin
      for (int u = 0; u < 2; u++) begin
        xl     = (u == 1) ? 64 : 32;
        tag    = $sformatf("x%0d", xl);
        exp_ir = (div_left[u] == 0) && (!holding[u] || out_ready[u]);
        check({tag, " out_valid"}, 64'(out_valid[u]), 64'(holding[u]));
        check({tag, " busy"},      64'(busy[u]),      64'(div_left[u] != 0));
        check({tag, " in_ready"},  64'(in_ready[u]),  64'(exp_ir));
        if (holding[u])         check({tag, " result"}, result[u], hold_val[u]);
        else if (zero_known[u]) check({tag, " result after reset"}, result[u], 64'h0);

        acc = !rst && in_valid[u] && exp_ir;
        if (rst) begin
          holding[u]    = 0;
          div_left[u]   = 0;
          zero_known[u] = 1;
        end else begin
          done = 0;
          dval = '0;
          if (div_left[u] == 1) begin
            done = 1;
            dval = div_val[u];
          end
          if (div_left[u] > 0) div_left[u]--;
          if (acc) begin
            mv = model(xl, lhs[u], rhs[u], func[u], alt[u], muldiv[u]);
            if (long_div(xl, lhs[u], rhs[u], func[u], muldiv[u])) begin
              div_left[u] = xl;
              div_val[u]  = mv;
            end else begin
              done = 1;
              dval = mv;
            end
          end
          if (done) begin
            holding[u]    = 1;
            hold_val[u]   = dval;
            zero_known[u] = 0;
          end else if (holding[u] && out_ready[u]) begin
            holding[u] = 0;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  bit rand_or = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) begin
      out_ready[0] = ($urandom_range(0, 3) != 0);
      out_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  // Present an op and hold it until the unit accepts it; returns #1 after the accept edge.
  task automatic issue(input int u, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] f, input logic al, input logic md);
    bit ok;
    ok = 0;
    lhs[u] = a; rhs[u] = b; func[u] = f; alt[u] = al; muldiv[u] = md;
    in_valid[u] = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready[u];
      @(posedge clk);
      #1;
    end
    in_valid[u] = 1'b0;
    if (!ok) fail_now("accept timeout");
  endtask

  // Wait for out_valid (out_ready assumed high); lat counts cycles from acceptance.
  task automatic wait_result(input int u, output int lat, output int nbusy, output int nir,
                             output logic [63:0] val);
    bit got;
    got = 0; lat = 0; nbusy = 0; nir = 0; val = '0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (out_valid[u]) begin
        got = 1;
        val = result[u];
      end else begin
        nbusy += int'(busy[u]);
        nir   += int'(in_ready[u]);
      end
      @(posedge clk);
      #1;
    end
    if (!got) fail_now("result timeout");
  endtask

  task automatic op_lit(input int u, input logic [63:0] a, input logic [63:0] b,
                        input logic [2:0] f, input logic al, input logic md,
                        input logic [63:0] exp, input int exp_lat, input string name);
    int          lat, nbusy, nir;
    logic [63:0] val;
    issue(u, a, b, f, al, md);
    wait_result(u, lat, nbusy, nir, val);
    check(name, val, exp);
    check({name, " latency"}, 64'(lat), 64'(exp_lat));
    if (exp_lat > 1) begin
      check({name, " busy cycles"}, 64'(nbusy), 64'(exp_lat - 1));
      check({name, " in_ready while dividing"}, 64'(nir), 64'h0);
    end
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 6))
      0: return 64'h0;
      1: return {64{1'b1}};
      2: return 64'h8000_0000;
      3: return 64'h8000_0000_0000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return -64'($urandom_range(1, 20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Hard stop in case something wedges despite the bounded waits.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int          start, lat, nbusy, nir;
    logic [63:0] val;
    logic [63:0] a, b;

    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 0; out_ready[u] = 1; alt[u] = 0; muldiv[u] = 0;
      lhs[u] = '0; rhs[u] = '0; func[u] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    armed = 1;
    rst   = 1'b0;

    // Hand-computed values pinning the model itself.
    check("model SUB",    model(32, 5, 7, 3'd0, 1, 0),                      64'hFFFF_FFFE);
    check("model SRA",    model(32, 64'h8000_0000, 64'h21, 3'd5, 1, 0),     64'hC000_0000);
    check("model SLT",    model(32, 64'hFFFF_FFFF, 1, 3'd2, 0, 0),          64'h1);
    check("model SLTU",   model(32, 64'hFFFF_FFFF, 1, 3'd3, 0, 0),          64'h0);
    check("model MULHSU", model(32, 64'hFFFF_FFFF, 2, 3'd2, 0, 1),          64'hFFFF_FFFF);
    check("model REM",    model(32, 64'hFFFF_FFF9, 2, 3'd6, 0, 1),          64'hFFFF_FFFF);
    check("model DIV64",  model(64, 64'hFFFF_FFFF_FFFF_FFF9, 2, 3'd4, 0, 1), 64'hFFFF_FFFF_FFFF_FFFD);

    // Eight back-to-back base ops, one per cycle.
    start = cyc;
    issue(0, 5,              7,     3'd0, 1, 0);
    issue(0, 64'h8000_0000,  64'h21, 3'd5, 1, 0);
    issue(0, 64'hFFFF_FFFF,  1,     3'd2, 0, 0);
    issue(0, 64'hFFFF_FFFF,  1,     3'd3, 0, 0);
    issue(0, 64'h1234_5678,  64'h1111_1111, 3'd0, 0, 0);
    issue(0, 64'h0000_00F1,  64'h24, 3'd1, 0, 0);
    issue(0, 64'h8000_0010,  4,     3'd5, 0, 0);
    issue(0, 64'hF0F0_F0F0,  64'h0FF0_0FF0, 3'd4, 0, 0);
    check("back-to-back cycles", 64'(cyc - start), 64'd8);

    // Multiplies.
    op_lit(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'd1, 0, 1, 64'h0,         1, "MULH -1*-1");
    op_lit(0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 3'd3, 0, 1, 64'hFFFF_FFFE, 1, "MULHU");
    op_lit(0, 64'hFFFF_FFFF, 64'h2,         3'd2, 0, 1, 64'hFFFF_FFFF, 1, "MULHSU -1*2");
    op_lit(0, 64'h1_0000,    64'h1_0000,    3'd0, 0, 1, 64'h0,         1, "MUL 2^16*2^16");

    // Iterating divides.
    op_lit(0, 64'hFFFF_FFF9, 2,   3'd4, 0, 1, 64'hFFFF_FFFD, 33, "DIV -7/2");
    op_lit(0, 64'hFFFF_FFF9, 2,   3'd6, 0, 1, 64'hFFFF_FFFF, 33, "REM -7/2");
    op_lit(0, 100,           7,   3'd5, 0, 1, 64'd14,        33, "DIVU 100/7");

    // Divide fast paths.
    op_lit(0, 5, 0, 3'd5, 0, 1, 64'hFFFF_FFFF, 1, "DIVU 5/0");
    op_lit(0, 5, 0, 3'd6, 0, 1, 64'h5,         1, "REM 5/0");
    op_lit(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'd4, 0, 1, 64'h8000_0000, 1, "DIV overflow");
    op_lit(0, 64'h8000_0000, 64'hFFFF_FFFF, 3'd6, 0, 1, 64'h0,         1, "REM overflow");

    // Backpressure: result held five cycles while a new request waits.
    out_ready[0] = 1'b0;
    issue(0, 100, 23, 3'd0, 0, 0);
    lhs[0] = 7; rhs[0] = 3; func[0] = 3'd0; alt[0] = 1; muldiv[0] = 0;
    in_valid[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("held result",    result[0], 64'd123);
      check("held out_valid", 64'(out_valid[0]), 64'h1);
      check("held in_ready",  64'(in_ready[0]),  64'h0);
      @(posedge clk);
      #1;
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("in_ready on release", 64'(in_ready[0]), 64'h1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_result(0, lat, nbusy, nir, val);
    check("op after release", val, 64'd4);
    check("op after release latency", 64'(lat), 64'd1);

    // Reset in the middle of a divide.
    issue(0, 1000, 3, 3'd4, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-reset out_valid", 64'(out_valid[0]), 64'h0);
    check("post-reset busy",      64'(busy[0]),      64'h0);
    check("post-reset in_ready",  64'(in_ready[0]),  64'h1);
    check("post-reset result",    result[0],         64'h0);
    @(posedge clk);
    #1;

    // 64-bit instance.
    op_lit(1, 64'h8000_0000_0000_0000, 3, 3'd5, 0, 1, 64'h2AAA_AAAA_AAAA_AAAA, 65, "DIVU64 2^63/3");
    op_lit(1, {64{1'b1}}, {64{1'b1}}, 3'd3, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1, "MULHU64");
    op_lit(1, 64'h8000_0000_0000_0000, {64{1'b1}}, 3'd4, 0, 1, 64'h8000_0000_0000_0000, 1, "DIV64 overflow");
    op_lit(1, 64'h8000_0000_0000_0000, 64'h3F, 3'd5, 1, 0, {64{1'b1}}, 1, "SRA64 by 63");

    // Randomized ops with random consumer backpressure; the monitor checks every cycle.
    rand_or = 1;
    for (int u = 0; u < 2; u++) begin
      repeat (250) begin
        a = pick();
        b = pick();
        issue(u, a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rand_or = 0;
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    repeat (70) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised, handshaked integer execute unit for the RISC-V core: the RV32I/RV64I register-register ALU operations plus the M-extension multiply/divide group. Single-cycle ops and multiplies return one cycle after acceptance. Divide/remainder runs an iterative restoring divider over XLEN cycles. Sits between decode/operand fetch and writeback, with valid/ready on both sides so writeback can stall it.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; transfer occurs when in_valid && in_ready at a rising edge.
- lhs  in  XLEN  operand A.
- rhs  in  XLEN  operand B.
- func  in  3  RISC-V funct3.
- alt  in  1  funct7[5]: SUB / SRA when muldiv=0; ignored when muldiv=1.
- muldiv  in  1  1 = M-extension op (funct7=0000001).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result; transfer when out_valid && out_ready.
- result  out  XLEN  result; stable while out_valid && !out_ready.
- busy  out  1  divider iterating (state DIV).

## Operation
- States: IDLE, DIV. Result register and out_valid are independent of state.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Back-to-back accepts are therefore allowed every cycle for non-divide ops.
- Base ops (muldiv=0), by func:
  - 0: ADD / SUB (alt).
  - 1: SLL.
  - 2: SLT, signed.
  - 3: SLTU.
  - 4: XOR.
  - 5: SRL / SRA (alt).
  - 6: OR.
  - 7: AND.
- Shift amount is rhs[SHW-1:0]; upper bits of rhs are ignored. Compare results are zero-extended 0/1. All arithmetic wraps modulo 2^XLEN.
- M ops (muldiv=1), by func:
  - 0: MUL, low XLEN bits.
  - 1: MULH, signed×signed, high half.
  - 2: MULHSU, signed lhs × unsigned rhs, high half.
  - 3: MULHU, high half.
  - 4: DIV.
  - 5: DIVU.
  - 6: REM.
  - 7: REMU.
  - Multiply uses a 2·XLEN-bit product of sign/zero-extended operands, computed in the acceptance cycle.
- Divide (func 4–7) fast paths, all with latency 1 and no DIV state:
  - rhs==0: quotient = all ones; remainder = lhs.
  - Signed overflow (lhs = -2^(XLEN-1), rhs = -1): quotient = lhs; remainder = 0.
- Divide normal path:
  - Latch magnitudes and result sign. Quotient sign = sign(lhs)^sign(rhs); remainder sign = sign(lhs), signed ops only.
  - Enter DIV with count=0. Each cycle performs one restoring step (shift, trial subtract, set quotient bit).
  - After XLEN steps, negate as required, load result, assert out_valid, and return to IDLE.
- Result/out_valid update rule:
  - When out_valid && out_ready and no new completion in the same cycle, out_valid falls.
  - A completion in the same cycle as a consumed result overwrites result and keeps out_valid high.
- in_valid while !in_ready is ignored. The producer must hold its request; the unit does not latch it.

## Timing
- Reset (rst=1 at an edge): state=IDLE, count=0, out_valid=0, result=0, busy=0. in_ready is therefore 1 after reset.
- Reset mid-divide aborts the operation with no result. It also discards a pending unconsumed result.
- Latency, measured from the acceptance edge T:
  - Non-divide ops and divide fast paths: out_valid high in cycle T+1.
  - Normal divide: busy high in cycles T+1..T+XLEN; out_valid high from cycle T+XLEN+1. That is 33 cycles for XLEN=32.
- in_ready is low during DIV, and while a result is held with out_ready=0.
- Throughput: 1/cycle for non-divide ops with out_ready=1. A new op may be accepted in the same cycle a divide result is consumed.

## Test plan
- **Reset:** hold rst 2 cycles mid-divide (XLEN=32) → out_valid=0, busy=0, in_ready=1, result=0 the cycle after release.
- **Base ops, out_ready=1, 8 back-to-back ops:** each result appears one cycle after acceptance with no bubbles.
  - SUB 5-7 → 0xFFFFFFFE.
  - SRA 0x80000000 by rhs=0x21 → 0xC0000000 (shamt 1).
  - SLT -1<1 → 1.
  - SLTU 0xFFFFFFFF<1 → 0.
- **Multiply:** expected results one cycle after acceptance.
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU -1×2 → 0xFFFFFFFF.
  - MUL 0x10000×0x10000 → 0.
- **Divide normal path:** DIV -7/2 → 0xFFFFFFFD (-3) at T+33, with busy high for cycles T+1..T+32 and in_ready low throughout. REM -7/2 → 0xFFFFFFFF. DIVU 100/7 → 14.
- **Divide edge cases, latency 1:**
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/-1 → 0x80000000.
  - REM 0x80000000/-1 → 0.
- **Backpressure:**
  - Hold out_ready=0 for 5 cycles after an ADD result → result stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → next op accepted that same cycle.
  - Repeat with XLEN=64 parameterisation: DIVU 2^63/3 → 0x2AAAAAAAAAAAAAAA at T+65.
